// File: rtl/pwm_pulse_gen.sv
// Prescaled square-wave generator for a step/direction motor driver.
// Direction changes are fenced by guard phases so dir_out never moves near an en_out edge.
module pwm_pulse_gen #(
  parameter int PARA_W     = 15,
  parameter int PRESCALE   = 100,
  parameter int DEAD_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PARA_W-1:0] para_in,
  input  logic              dir_in,
  output logic              dir_out,
  output logic              en_out,
  output logic              running
);

  typedef enum logic [1:0] {IDLE, RUN, DEAD, SETUP} state_t;

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DEAD_W = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_TICKS - 1);

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PARA_W-1:0]   per_cnt_q, per_cnt_d;
  logic [PARA_W-1:0]   per_reg_q, per_reg_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic                dir_q, dir_d;
  logic                en_q, en_d;
  logic                running_q, running_d;

  logic tick, per_done, dead_done, boundary, para_zero;

  assign tick      = (pre_cnt_q == PRE_LAST);
  assign per_done  = tick && (per_cnt_q == per_reg_q - PARA_W'(1));
  assign dead_done = tick && (dead_cnt_q == DEAD_LAST);
  assign boundary  = per_done && en_q;
  assign para_zero = (para_in == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      per_cnt_q  <= '0;
      per_reg_q  <= '0;
      dead_cnt_q <= '0;
      dir_q      <= 1'b0;
      en_q       <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      per_cnt_q  <= per_cnt_d;
      per_reg_q  <= per_reg_d;
      dead_cnt_q <= dead_cnt_d;
      dir_q      <= dir_d;
      en_q       <= en_d;
      running_q  <= running_d;
    end
  end

  // RUN only reconsiders para_in/dir_in at the falling edge of en_out
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!para_zero) state_d = (dir_in == dir_q) ? RUN : SETUP;
      RUN: begin
        if (boundary) begin
          if (para_zero)            state_d = IDLE;
          else if (dir_in != dir_q) state_d = DEAD;
        end
      end
      DEAD:  if (dead_done) state_d = SETUP;
      SETUP: if (dead_done) state_d = para_zero ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
    per_cnt_d  = per_cnt_q;
    per_reg_d  = per_reg_q;
    dead_cnt_d = dead_cnt_q;
    dir_d      = dir_q;
    en_d       = en_q;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (!para_zero && (dir_in != dir_q)) dir_d = dir_in;
        if (state_d == RUN) begin
          per_reg_d = para_in;
          en_d      = 1'b1;
        end
      end
      RUN: begin
        if (per_done) begin
          per_cnt_d = '0;
          en_d      = ~en_q;
          if (boundary && (state_d == RUN)) per_reg_d = para_in;
        end else if (tick) begin
          per_cnt_d = per_cnt_q + PARA_W'(1);
        end
      end
      DEAD: begin
        en_d = 1'b0;
        if (tick)      dead_cnt_d = dead_cnt_q + DEAD_W'(1);
        if (dead_done) dir_d = dir_in;
      end
      SETUP: begin
        en_d = 1'b0;
        if (tick) dead_cnt_d = dead_cnt_q + DEAD_W'(1);
        if (state_d == RUN) begin
          per_reg_d = para_in;
          en_d      = 1'b1;
        end
      end
      default: en_d = 1'b0;
    endcase
    // every phase starts tick-aligned
    if (state_d != state_q) begin
      pre_cnt_d  = '0;
      per_cnt_d  = '0;
      dead_cnt_d = '0;
    end
  end

  always_comb begin
    running_d = (state_d == RUN);
    dir_out   = dir_q;
    en_out    = en_q;
    running   = running_q;
  end

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// Directed bench for pwm_pulse_gen with PRESCALE=2, DEAD_TICKS=3, PARA_W=15.
// Phase lengths are counted in clk edges and compared with hand-computed values.
module tb_pwm_pulse_gen;

  localparam int PARA_W = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [PARA_W-1:0] para_in;
  logic              dir_in;
  logic              dir_out;
  logic              en_out;
  logic              running;

  int checks   = 0;
  int failures = 0;
  int len;

  pwm_pulse_gen #(.PARA_W(PARA_W), .PRESCALE(2), .DEAD_TICKS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .para_in (para_in),
    .dir_in  (dir_in),
    .dir_out (dir_out),
    .en_out  (en_out),
    .running (running)
  );

  always #5 clk = ~clk;

  // advance n edges and land 1 time unit after the last one
  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [PARA_W-1:0] para, input logic dir);
    para_in = para;
    dir_in  = dir;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // counts edges for which en_out keeps level lvl; capped at limit
  task automatic measureLevel(input logic lvl, input int limit, output int n);
    n = 0;
    while ((en_out == lvl) && (n < limit)) begin
      stepClk(1);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    stepClk(2);
    checkOutput("reset_en", int'(en_out), 0);
    checkOutput("reset_dir", int'(dir_out), 0);
    checkOutput("reset_running", int'(running), 0);
    rst = 1'b0;
    stepClk(3);
    checkOutput("idle_en", int'(en_out), 0);

    // steady run, para=4: 8 clk high, 8 clk low
    applyStimulus(15'd4, 1'b0);
    stepClk(1);
    checkOutput("start_en", int'(en_out), 1);
    checkOutput("start_running", int'(running), 1);
    measureLevel(1'b1, 100, len);
    checkOutput("steady_high", len, 8);
    measureLevel(1'b0, 100, len);
    checkOutput("steady_low", len, 8);
    checkOutput("steady_dir", int'(dir_out), 0);

    // period change requested inside a high phase
    applyStimulus(15'd2, 1'b0);
    measureLevel(1'b1, 100, len);
    checkOutput("change_cur_high", len, 8);
    measureLevel(1'b0, 100, len);
    measureLevel(1'b1, 100, len);
    checkOutput("change_new_high", len, 4);
    measureLevel(1'b0, 100, len);
    checkOutput("change_new_low", len, 4);

    // direction change: high completes, 6 clk guard, dir flips, 6 clk guard
    applyStimulus(15'd2, 1'b1);
    measureLevel(1'b1, 100, len);
    checkOutput("dirchg_high", len, 4);
    checkOutput("dirchg_running_dead", int'(running), 0);
    stepClk(5);
    checkOutput("dirchg_dir_early", int'(dir_out), 0);
    checkOutput("dirchg_en_dead", int'(en_out), 0);
    stepClk(1);
    checkOutput("dirchg_dir_flip", int'(dir_out), 1);
    measureLevel(1'b0, 100, len);
    checkOutput("dirchg_setup_len", len, 6);
    checkOutput("dirchg_running", int'(running), 1);

    // asynchronous reset in the middle of a high phase
    stepClk(1);
    checkOutput("prereset_en", int'(en_out), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_en", int'(en_out), 0);
    checkOutput("async_dir", int'(dir_out), 0);
    checkOutput("async_running", int'(running), 0);
    applyStimulus('0, 1'b0);
    stepClk(2);
    checkOutput("reset_hold_en", int'(en_out), 0);
    rst = 1'b0;
    stepClk(2);

    // stop: para=0 during high, high completes then IDLE
    applyStimulus(15'd4, 1'b0);
    stepClk(1);
    checkOutput("stop_start_en", int'(en_out), 1);
    applyStimulus('0, 1'b0);
    measureLevel(1'b1, 100, len);
    checkOutput("stop_high", len, 8);
    checkOutput("stop_running", int'(running), 0);
    stepClk(10);
    checkOutput("stop_idle_en", int'(en_out), 0);
    checkOutput("stop_idle_running", int'(running), 0);

    // start from IDLE with a new direction and maximum period
    applyStimulus(15'h7FFF, 1'b1);
    stepClk(1);
    checkOutput("max_dir", int'(dir_out), 1);
    checkOutput("max_en_setup", int'(en_out), 0);
    measureLevel(1'b0, 100, len);
    checkOutput("max_setup_len", len, 6);
    checkOutput("max_running", int'(running), 1);
    applyStimulus('0, 1'b1);
    measureLevel(1'b1, 70000, len);
    checkOutput("max_high", len, 65534);
    checkOutput("max_stop_running", int'(running), 0);
    checkOutput("max_stop_dir", int'(dir_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
